// File: rtl/tdm_chan_mux.sv
// TDM channel mux/demux: TX time-multiplexes NCH channel words onto one registered bus
// (auto scan or fixed select); RX demultiplexes a bus word into per-channel hold registers.
module tdm_chan_mux #(
   parameter  int unsigned NCH  = 4,
   parameter  int unsigned W    = 8,
   localparam int unsigned SELW = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic [SELW-1:0]   fix_sel,
   input  logic [NCH*W-1:0]  din,
   output logic [W-1:0]      bus_data,
   output logic [SELW-1:0]   bus_sel,
   output logic              bus_valid,
   output logic              frame_start,
   input  logic [W-1:0]      rx_data,
   input  logic [SELW-1:0]   rx_sel,
   input  logic              rx_valid,
   output logic [NCH*W-1:0]  dout,
   output logic [NCH-1:0]    dout_upd,
   output logic              frame_done
);

   logic [SELW-1:0]  r_cnt;
   logic [W-1:0]     r_bus_data;
   logic [SELW-1:0]  r_bus_sel;
   logic             r_bus_valid;
   logic             r_frame_start;
   logic [NCH*W-1:0] r_dout;
   logic [NCH-1:0]   r_dout_upd;
   logic             r_frame_done;

   logic [SELW-1:0]  w_sel;
   logic [W-1:0]     w_tx_word;

   always_comb begin
      w_sel     = mode ? fix_sel : r_cnt;
      w_tx_word = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (SELW'(k) == w_sel) w_tx_word = din[k*W +: W];
      end
   end

   // In fixed mode the counter tracks fix_sel+1 so a return to auto resumes after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_bus_data    <= '0;
         r_bus_sel     <= '0;
         r_bus_valid   <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (en) begin
         r_cnt         <= w_sel + SELW'(1);
         r_bus_data    <= w_tx_word;
         r_bus_sel     <= w_sel;
         r_bus_valid   <= 1'b1;
         r_frame_start <= !mode && (r_cnt == '0);
      end else begin
         r_bus_valid   <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_upd   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (rx_valid) begin
            for (int unsigned k = 0; k < NCH; k++) begin
               if (SELW'(k) == rx_sel) r_dout[k*W +: W] <= rx_data;
            end
         end
         r_dout_upd   <= rx_valid ? (NCH'(1) << rx_sel) : '0;
         r_frame_done <= rx_valid && (rx_sel == SELW'(NCH - 1));
      end
   end

   assign bus_data    = r_bus_data;
   assign bus_sel     = r_bus_sel;
   assign bus_valid   = r_bus_valid;
   assign frame_start = r_frame_start;
   assign dout        = r_dout;
   assign dout_upd    = r_dout_upd;
   assign frame_done  = r_frame_done;

endmodule

// File: doc/tdm_chan_mux.md
Name: tdm_chan_mux

Overview:
- Parametrised, registered successor to the 4:1 mux / 1:4 demux pair, for POKEY audio/keyboard channel routing.
- TX side time-division multiplexes NCH channel words of width W onto one shared bus. It runs in two modes: auto round-robin scan, or fixed select.
- RX side demultiplexes a bus of the same format into per-channel hold registers, with update strobes.
- Sits between the channel generators and the mixer/output stage. TX and RX are independent and can be looped back.

Parameters:
- NCH, 4, channel count; power of two, 2..16.
- W, 8, channel word width in bits, 1..16.
- SELW, $clog2(NCH), select width; derived, never overridden.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, TX slot tick; one bus slot per cycle with en=1.
- mode, input, 1, 0 = auto scan, 1 = fixed select.
- fix_sel, input, SELW, channel driven while mode=1.
- din, input, NCH*W, TX channel words; channel k is din[k*W +: W].
- bus_data, output, W, registered TX word.
- bus_sel, output, SELW, channel index of bus_data.
- bus_valid, output, 1, one-cycle pulse, bus_data/bus_sel valid.
- frame_start, output, 1, pulse with bus_valid when auto mode emits channel 0.
- rx_data, input, W, RX word.
- rx_sel, input, SELW, RX channel index.
- rx_valid, input, 1, RX word strobe.
- dout, output, NCH*W, RX hold registers; channel k is dout[k*W +: W].
- dout_upd, output, NCH, one-hot one-cycle pulse for the channel written.
- frame_done, output, 1, pulse when an RX word for channel NCH-1 is written.

Behaviour:
- Reset: asynchronous assert, synchronous release. While rst_n=0 every output is 0 and the scan counter is 0. Reset mid-frame discards the frame; after release, the first auto slot is channel 0 with frame_start=1.
- TX latency: 1 cycle. If en=1 at edge t, then at edge t+1 bus_data = din slice of the selected channel as sampled at t, bus_sel = that channel, and bus_valid = 1.
- TX outputs when en=0:
  - bus_valid and frame_start return to 0 the next cycle.
  - bus_data and bus_sel hold their last value.
- Auto mode (mode=0):
  - The selected channel is the scan counter cnt.
  - On each en, cnt advances by 1 and wraps NCH-1 -> 0.
  - frame_start = 1 exactly on slots emitting cnt=0.
- Fixed mode (mode=1):
  - The selected channel is fix_sel. cnt is frozen at fix_sel+1 mod NCH, updated on each en.
  - frame_start is always 0.
  - fix_sel may change on any cycle and takes effect on the next en.
- Mode switch: mode is sampled together with en.
  - Switching 1->0 resumes the scan at (last fix_sel + 1) mod NCH. No forced restart; frame_start fires only when the scan reaches 0.
  - Switching 0->1 takes effect on the very next en slot.
- RX:
  - On rx_valid=1 at edge t: at t+1 the dout slice rx_sel equals rx_data, dout_upd = 1<<rx_sel, and frame_done = (rx_sel == NCH-1).
  - All other dout slices hold.
  - When rx_valid=0, dout_upd and frame_done are 0. The RX side has no mode or enable dependency.
- Back-to-back rx_valid on consecutive cycles with the same rx_sel: the last write wins and a dout_upd pulse is produced each cycle.
- Simultaneous TX and RX activity is fully independent. Loopback (bus_* wired to rx_*) reproduces din into dout with 2-cycle latency.
- dout is never cleared except by reset.

Test Plan:
- Reset/idle: hold rst_n=0, toggle din -> all outputs 0. Release rst_n, en=1 in auto, din = {8'h44,8'h33,8'h22,8'h11} -> bus_data = 11,22,33,44,11… with bus_sel 0,1,2,3,0 and frame_start on slots 0 and 4.
- Gapped en: en pattern 1,0,0,1 -> two bus_valid pulses with bus_sel 0 then 1; bus_data/bus_sel held during the gap; no extra frame_start.
- Fixed mode: mode=1, fix_sel=2, 3 ticks -> bus_data = 8'h33 three times, frame_start=0. Then mode=0 -> next slots are 3, 0 (frame_start=1), 1.
- RX write: rx_valid pulse with rx_sel=1, rx_data=8'hA5 -> next cycle dout[15:8]=A5, dout_upd=4'b0010, other slices unchanged. rx_sel=3 -> frame_done=1.
- Loopback: wire bus_* to rx_*, run auto for 2 frames with random din -> dout equals din 2 cycles after each channel's slot; frame_done every 4 slots.
- Reset mid-operation: assert rst_n low on the bus_sel=2 slot -> outputs clear immediately (async). After release, the first slot is channel 0 with frame_start=1.
